writeback: RTL

WRITEBACK -- requirements
Module: writeback

---
 rtl/writeback_pkg.sv | 36 +++
 rtl/writeback_flag_unit.sv | 20 ++
 rtl/writeback.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/writeback_pkg.sv
// Shared types and constants for the writeback stage.
package writeback_pkg;

  localparam int DATA_W     = 36;
  localparam int LANE_W     = 32;
  localparam int LANES      = 4;
  localparam int REG_ADDR_W = 5;

  // One complete execute-stage result, as parked in the collision hold register.
  typedef struct packed {
    logic                               s_we;
    logic                               v_we;
    logic                               set_flags;
    logic [REG_ADDR_W-1:0]              r_addr;
    logic [REG_ADDR_W-1:0]              v_addr;
    logic [DATA_W-1:0]                  sdata;
    logic [LANES-1:0][LANE_W-1:0]       vdata;
    logic [LANES-1:0]                   mask;
  } ex_entry_t;

  // Branch condition flags derived from a committed scalar result.
  typedef struct packed {
    logic nz;
    logic ez;
    logic lz;
    logic gz;
    logic le;
    logic ge;
  } flags_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/writeback_flag_unit.sv
// Combinational condition-flag derivation from a signed 36-bit result.
module flag_unit
  import writeback_pkg::*;
(
  input  logic [DATA_W-1:0] result,
  output flags_t            flags
);

  // Zero / sign based compare flags; bit 35 is the sign.
  always_comb begin
    flags    = '0;
    flags.ez = (result == {DATA_W{1'b0}});
    flags.nz = ~flags.ez;
    flags.lz = result[DATA_W-1];
    flags.gz = ~flags.lz & ~flags.ez;
    flags.le = flags.lz | flags.ez;
    flags.ge = ~flags.lz;
  end

endmodule

// File: rtl/writeback.sv
// Writeback stage: merges execute results and load responses onto the
// scalar and vector register-file write ports, parking the execute entry
// for one cycle when it competes with a load for the scalar port.
module writeback
  import writeback_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_s_we,
  input  logic                          in_v_we,
  input  logic                          in_set_flags,
  input  logic [REG_ADDR_W-1:0]         in_r_addr,
  input  logic [REG_ADDR_W-1:0]         in_v_addr,
  input  logic [DATA_W-1:0]             in_sdata,
  input  logic [LANES-1:0][LANE_W-1:0]  in_vdata,
  input  logic [LANES-1:0]              in_mask,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [REG_ADDR_W-1:0]         ld_addr,
  input  logic [DATA_W-1:0]             ld_data,
  output logic                          s_wr_en,
  output logic [REG_ADDR_W-1:0]         r_write_addr,
  output logic [DATA_W-1:0]             write_data,
  output logic [LANES-1:0]              mask,
  output logic [REG_ADDR_W-1:0]         v_write_addr,
  output logic [LANES-1:0][LANE_W-1:0]  write_vector,
  output logic                          nz,
  output logic                          ez,
  output logic                          lz,
  output logic                          gz,
  output logic                          le,
  output logic                          ge
);

  wb_state_t                     state_q, state_d;
  ex_entry_t                     hold_q, hold_d;
  logic                          s_wr_en_q, s_wr_en_d;
  logic [REG_ADDR_W-1:0]         r_write_addr_q, r_write_addr_d;
  logic [DATA_W-1:0]             write_data_q, write_data_d;
  logic [LANES-1:0]              mask_q, mask_d;
  logic [REG_ADDR_W-1:0]         v_write_addr_q, v_write_addr_d;
  logic [LANES-1:0][LANE_W-1:0]  write_vector_q, write_vector_d;
  flags_t                        flags_q, flags_d;

  ex_entry_t         ex_entry;
  logic              hold_valid;
  logic              ex_fire;
  logic              ld_fire;
  logic              ex_scalar;
  logic              collision;
  logic              ex_vec;
  logic [DATA_W-1:0] fu_in;
  logic              fu_upd;
  flags_t            fu_out;

  assign hold_valid = (state_q == ST_HOLD);
  assign in_ready   = ~hold_valid;
  assign ld_ready   = ~hold_valid;
  assign ex_fire    = in_valid & in_ready;
  assign ld_fire    = ld_valid & ld_ready;
  assign ex_scalar  = ex_fire & in_s_we;
  // Only a scalar-writing execute entry competes with a load for the port.
  assign collision  = ex_scalar & ld_fire;
  assign ex_vec     = ex_fire & in_v_we & ~collision;

  assign ex_entry = '{s_we:      in_s_we,
                      v_we:      in_v_we,
                      set_flags: in_set_flags,
                      r_addr:    in_r_addr,
                      v_addr:    in_v_addr,
                      sdata:     in_sdata,
                      vdata:     in_vdata,
                      mask:      in_mask};

  // Single flag deriver sits on whichever entry commits this cycle.
  flag_unit u_flag_unit (
    .result (fu_in),
    .flags  (fu_out)
  );

  // Next-state and next write-port values: drain the hold entry, or merge new transfers.
  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    s_wr_en_d      = 1'b0;
    r_write_addr_d = r_write_addr_q;
    write_data_d   = write_data_q;
    mask_d         = {LANES{1'b0}};
    v_write_addr_d = v_write_addr_q;
    write_vector_d = write_vector_q;
    fu_in          = in_sdata;
    fu_upd         = 1'b0;
    case (state_q)
      ST_HOLD: begin
        // Both readies are low here, so the held entry owns every port.
        state_d        = ST_IDLE;
        hold_d         = '0;
        s_wr_en_d      = hold_q.s_we;
        r_write_addr_d = hold_q.r_addr;
        write_data_d   = hold_q.sdata;
        mask_d         = hold_q.v_we ? hold_q.mask : {LANES{1'b0}};
        v_write_addr_d = hold_q.v_addr;
        write_vector_d = hold_q.vdata;
        fu_in          = hold_q.sdata;
        fu_upd         = hold_q.set_flags;
      end
      ST_IDLE: begin
        // Load wins the scalar port on a collision; execute is parked whole.
        state_d        = collision ? ST_HOLD : ST_IDLE;
        hold_d         = collision ? ex_entry : hold_q;
        s_wr_en_d      = ld_fire | ex_scalar;
        r_write_addr_d = ld_fire ? ld_addr :
                         (ex_scalar ? in_r_addr : r_write_addr_q);
        write_data_d   = ld_fire ? ld_data :
                         (ex_scalar ? in_sdata : write_data_q);
        mask_d         = ex_vec ? in_mask : {LANES{1'b0}};
        v_write_addr_d = ex_vec ? in_v_addr : v_write_addr_q;
        write_vector_d = ex_vec ? in_vdata : write_vector_q;
        fu_in          = in_sdata;
        fu_upd         = ex_fire & in_set_flags & ~collision;
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end
    endcase
    flags_d = fu_upd ? fu_out : flags_q;
  end

  // State, hold entry, write ports and flags; reset discards any held entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      hold_q         <= '0;
      s_wr_en_q      <= 1'b0;
      r_write_addr_q <= {REG_ADDR_W{1'b0}};
      write_data_q   <= {DATA_W{1'b0}};
      mask_q         <= {LANES{1'b0}};
      v_write_addr_q <= {REG_ADDR_W{1'b0}};
      write_vector_q <= '0;
      flags_q        <= '0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      s_wr_en_q      <= s_wr_en_d;
      r_write_addr_q <= r_write_addr_d;
      write_data_q   <= write_data_d;
      mask_q         <= mask_d;
      v_write_addr_q <= v_write_addr_d;
      write_vector_q <= write_vector_d;
      flags_q        <= flags_d;
    end
  end

  assign s_wr_en      = s_wr_en_q;
  assign r_write_addr = r_write_addr_q;
  assign write_data   = write_data_q;
  assign mask         = mask_q;
  assign v_write_addr = v_write_addr_q;
  assign write_vector = write_vector_q;
  assign nz           = flags_q.nz;
  assign ez           = flags_q.ez;
  assign lz           = flags_q.lz;
  assign gz           = flags_q.gz;
  assign le           = flags_q.le;
  assign ge           = flags_q.ge;

endmodule
